// File: rtl/dpcm_decompressor.sv
// 565 DPCM pixel decompressor: rebuilds 24-bit RGB from 16-bit codes in raster order.
// Each pixel is predicted from the mean of its left and upper reconstructed neighbours.
module dpcm_decompressor #(
    parameter int unsigned H_RES = 800,
    parameter int unsigned V_RES = 600
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    output logic        o_valid,
    output logic [23:0] o_data,
    output logic        o_sol,
    output logic        o_sof
);

    localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [23:0] MID_GREY = 24'h7F7F7F;

    logic [COL_W-1:0] col_q, col_cur, col_d;
    logic [ROW_W-1:0] row_q, row_cur, row_d;
    logic [23:0]      left_q;
    logic [23:0]      line_q [H_RES-1];
    logic [23:0]      left_px, up_px, pix;
    logic             first_col, first_row;
    logic [7:0]       d_r, d_g, d_b;

    // 9-bit sum keeps the carry so the halving is exact before the mod-256 add.
    function automatic logic [7:0] recon(input logic [7:0] l, input logic [7:0] u,
                                         input logic [7:0] d);
        logic [8:0] sum;
        sum = {1'b0, l} + {1'b0, u};
        return sum[8:1] + d;
    endfunction

    always_comb begin
        col_cur   = i_clear ? '0 : col_q;
        row_cur   = i_clear ? '0 : row_q;
        first_col = (col_cur == '0);
        first_row = (row_cur == '0);

        left_px = first_col ? MID_GREY : left_q;
        up_px   = first_row ? MID_GREY : line_q[H_RES-2];

        d_r = {i_data[15:11], 3'b000};
        d_g = {i_data[10:5], 2'b00};
        d_b = {i_data[4:0], 3'b000};

        pix = {recon(left_px[23:16], up_px[23:16], d_r),
               recon(left_px[15:8],  up_px[15:8],  d_g),
               recon(left_px[7:0],   up_px[7:0],   d_b)};

        if (col_cur == COL_W'(H_RES - 1)) begin
            col_d = '0;
            row_d = (row_cur == ROW_W'(V_RES - 1)) ? '0 : row_cur + ROW_W'(1);
        end else begin
            col_d = col_cur + COL_W'(1);
            row_d = row_cur;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sol   <= 1'b0;
            o_sof   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            left_q  <= '0;
            for (int i = 0; i < int'(H_RES) - 1; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_data <= pix;
                o_sol  <= first_col;
                o_sof  <= first_col && first_row;
                left_q <= pix;
                col_q  <= col_d;
                row_q  <= row_d;
                // Tail of the shift chain is the pixel one full line back.
                for (int i = int'(H_RES) - 2; i > 0; i--) begin
                    line_q[i] <= line_q[i-1];
                end
                line_q[0] <= left_q;
            end else if (i_clear) begin
                col_q <= '0;
                row_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dpcm_decompressor.sv
// Bench for dpcm_decompressor: fixed vectors plus random streams checked against
// a 2-D image model of the decoder and a matching encoder.
module tb_dpcm_decompressor;

    localparam int H = 32;
    localparam int V = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data = '0;
    logic        o_valid;
    logic [23:0] o_data;
    logic        o_sol;
    logic        o_sof;

    dpcm_decompressor #(
        .H_RES(H),
        .V_RES(V)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clear (clear),
        .i_valid (valid),
        .i_data  (data),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sol   (o_sol),
        .o_sof   (o_sof)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: reconstructed image of the current frame plus raster position.
    logic [23:0] img [V][H];
    int          mrow = 0;
    int          mcol = 0;
    logic [23:0] last_px = '0;
    int          sol_count = 0;
    int          sof_count = 0;

    typedef struct {
        bit          clr;
        logic [15:0] code;
        logic [23:0] exp;
        bit          sol;
        bit          sof;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Decode (enc=0, uses code_in) or encode-then-decode (enc=1, uses target) one pixel.
    task automatic model_px(input bit clr, input bit enc, input logic [23:0] target,
                            input logic [15:0] code_in, output logic [15:0] code,
                            output logic [23:0] px, output bit sol, output bit sof);
        int lft, up, rf, d, sh, scale, pos, dmask, val;
        if (clr) begin
            mrow = 0;
            mcol = 0;
        end
        code = enc ? 16'h0000 : code_in;
        px   = '0;
        for (int ch = 0; ch < 3; ch++) begin
            sh    = 16 - 8 * ch;
            scale = (ch == 1) ? 4 : 8;
            dmask = (ch == 1) ? 63 : 31;
            pos   = (ch == 0) ? 11 : ((ch == 1) ? 5 : 0);
            lft   = (mcol == 0) ? 127 : int'(img[mrow][mcol-1][sh+:8]);
            up    = (mrow == 0) ? 127 : int'(img[mrow-1][mcol][sh+:8]);
            rf    = (lft + up) / 2;
            if (enc) begin
                d    = ((int'(target[sh+:8]) - rf + 256) % 256) / scale;
                code = code | 16'(d << pos);
            end else begin
                d = (int'(code) >> pos) & dmask;
            end
            val = (rf + d * scale) % 256;
            px[sh+:8] = 8'(val);
        end
        img[mrow][mcol] = px;
        sol = (mcol == 0);
        sof = (mcol == 0) && (mrow == 0);
        mcol++;
        if (mcol == H) begin
            mcol = 0;
            mrow = (mrow + 1) % V;
        end
    endtask

    task automatic drive(input bit clr, input logic [15:0] code);
        @(negedge clk);
        clear = clr;
        valid = 1'b1;
        data  = code;
        @(posedge clk);
        #1;
        if (o_valid && o_sol) sol_count++;
        if (o_valid && o_sof) sof_count++;
    endtask

    task automatic send(input bit clr, input bit enc, input logic [23:0] target,
                        input logic [15:0] code_in);
        logic [15:0] code;
        logic [23:0] px;
        bit          sol, sof;
        model_px(clr, enc, target, code_in, code, px, sol, sof);
        drive(clr, code);
        check("valid", 32'(o_valid), 32'(1'b1));
        check("data", 32'(o_data), 32'(px));
        check("sol", 32'(o_sol), 32'(sol));
        check("sof", 32'(o_sof), 32'(sof));
        last_px = px;
    endtask

    task automatic apply_vec(input vec_t v);
        logic [15:0] code;
        logic [23:0] px;
        bit          sol, sof;
        model_px(v.clr, 1'b0, 24'h0, v.code, code, px, sol, sof);
        drive(v.clr, v.code);
        check("vec_valid", 32'(o_valid), 32'(1'b1));
        check("vec_data", 32'(o_data), 32'(v.exp));
        check("vec_sol", 32'(o_sol), 32'(v.sol));
        check("vec_sof", 32'(o_sof), 32'(v.sof));
        last_px = v.exp;
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
        clear = 1'b0;
        data  = 16'($urandom);
        @(posedge clk);
        #1;
        check("idle_valid", 32'(o_valid), 32'(1'b0));
        check("idle_hold", 32'(o_data), 32'(last_px));
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        valid = 1'b0;
        clear = 1'b0;
        #1;
        check("rst_valid", 32'(o_valid), 32'(1'b0));
        check("rst_data", 32'(o_data), 32'h0);
        check("rst_sol", 32'(o_sol), 32'(1'b0));
        check("rst_sof", 32'(o_sof), 32'(1'b0));
        @(negedge clk);
        rst_n   = 1'b1;
        mrow    = 0;
        mcol    = 0;
        last_px = '0;
    endtask

    initial begin
        vecs[0] = '{clr: 1'b1, code: 16'h0000, exp: 24'h7F7F7F, sol: 1'b1, sof: 1'b1};
        vecs[1] = '{clr: 1'b1, code: 16'h0841, exp: 24'h878787, sol: 1'b1, sof: 1'b1};
        vecs[2] = '{clr: 1'b0, code: 16'h0000, exp: 24'h838383, sol: 1'b0, sof: 1'b0};
        vecs[3] = '{clr: 1'b1, code: 16'h7800, exp: 24'hF77F7F, sol: 1'b1, sof: 1'b1};
        vecs[4] = '{clr: 1'b1, code: 16'h8000, exp: 24'hFF7F7F, sol: 1'b1, sof: 1'b1};
        // (FF+7F)>>1 = BF, BF+F8 wraps to B7.
        vecs[5] = '{clr: 1'b0, code: 16'hF800, exp: 24'hB77F7F, sol: 1'b0, sof: 1'b0};
        vecs[6] = '{clr: 1'b1, code: 16'h07FF, exp: 24'h7F7B77, sol: 1'b1, sof: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(o_valid), 32'(1'b0));
        check("reset_data", 32'(o_data), 32'h0);
        check("reset_sol", 32'(o_sol), 32'(1'b0));
        check("reset_sof", 32'(o_sof), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // First pixel straight out of reset, no clear.
        apply_vec(vecs[0]);
        idle();
        for (int i = 0; i < 7; i++) begin
            apply_vec(vecs[i]);
            if (i % 2 == 1) idle();
        end

        // One full line of zero codes with gaps, then the first pixel of row 1.
        sol_count = 0;
        send(1'b1, 1'b0, 24'h0, 16'h0000);
        for (int i = 1; i <= H; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send(1'b0, 1'b0, 24'h0, 16'h0000);
        end
        check("line_sol_count", 32'(sol_count), 32'd2);

        // Random codes across a full frame plus one, no idle cycles.
        sof_count = 0;
        send(1'b1, 1'b0, 24'h0, 16'($urandom));
        for (int i = 1; i <= H * V; i++) begin
            send(1'b0, 1'b0, 24'h0, 16'($urandom));
        end
        check("frame_sof_count", 32'(sof_count), 32'd2);

        // Round trip: random image through the encoder, with a mid-frame clear and reset.
        send(1'b1, 1'b1, 24'($urandom), 16'h0);
        for (int i = 1; i < 3 * H + 7; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            send(1'b0, 1'b1, 24'($urandom), 16'h0);
        end
        send(1'b1, 1'b1, 24'($urandom), 16'h0);
        for (int i = 1; i < H + 9; i++) begin
            send(1'b0, 1'b1, 24'($urandom), 16'h0);
        end
        async_reset();
        for (int i = 0; i < 2 * H + 5; i++) begin
            if ($urandom_range(0, 5) == 0) idle();
            send(1'b0, 1'b1, 24'($urandom), 16'h0);
        end
        send(1'b1, 1'b1, 24'($urandom), 16'h0);
        for (int i = 1; i < 2 * H; i++) begin
            send(1'b0, 1'b1, 24'($urandom), 16'h0);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
